certificate_responder: RTL and testbench
========================================

# certificate_responder

Responder end of the authentication GET_CERTIFICATE exchange: accepts a parsed GET_CERTIFICATE request, validates header, slot, offset and length, then streams a CERTIFICATE response (4-byte header plus certificate-chain bytes read from a slot-indexed chain memory) or a 4-byte ERROR response. It sits on the device side opposite the initiator's certificate control FSM, between the request parser and the transport byte serializer.

## Interface
Parameters:
- MAX_CHUNK, 16'd512, maximum chain bytes returned in one CERTIFICATE response.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  responder accepts request; transfer on req_valid & req_ready.
- req_header  in  32  {ProtocolVersion[31:24], MessageType[23:16], Param1[15:8], Param2[7:0]}; slot = Param1[1:0].
- req_offset  in  16  byte offset into chain.
- req_length  in  16  bytes requested.
- slot_valid_mask  in  4  bit n = slot n provisioned.
- slot_len  in  64  packed chain lengths, slot n at [16n+15:16n].
- mem_rd_en  out  1  chain memory read strobe.
- mem_addr  out  18  {slot[1:0], byte_addr[15:0]}.
- mem_data  in  8  read data, valid the cycle after mem_rd_en, held until next mem_rd_en.
- tx_valid  out  1  response byte valid.
- tx_ready  in  1  sink accepts; byte transfers on tx_valid & tx_ready.
- tx_data  out  8  response byte.
- tx_last  out  1  final byte of message, qualified by tx_valid.
- busy  out  1  high in every state except IDLE.
- resp_done  out  1  one-cycle pulse after last byte of CERTIFICATE accepted.
- resp_error  out  1  one-cycle pulse after last byte of ERROR accepted.

## Operation
- States: IDLE, CHECK, HDR, FETCH, SEND, ERR_HDR.
- IDLE: req_ready=1. On accept, latch header, offset, length, slot; -> CHECK.
- CHECK (1 cycle), first failing check wins: version!=8'h01 -> code 8'h02; type!=8'h82 -> code 8'h01; slot_valid_mask[slot]==0 -> 8'h01; req_length==0 -> 8'h01; req_offset>=slot_len[slot] -> 8'h01. Any failure -> ERR_HDR; else -> HDR.
- Count n = min(req_length, MAX_CHUNK, slot_len[slot]-req_offset), 16-bit unsigned; subtraction only evaluated when offset<len (no wrap). Byte index i runs 0..n-1.
- HDR: bytes 8'h01, 8'h02, {6'b0,slot}, 8'h00, one per accepted transfer; after byte 3 -> FETCH.
- FETCH (1 cycle): mem_rd_en=1, mem_addr={slot, req_offset+i} (16-bit sum, no overflow since offset+i<len<=65535); -> SEND.
- SEND: tx_data=mem_data, tx_valid=1, tx_last=(i==n-1). On accept: if last -> IDLE with resp_done pulse, else i++ -> FETCH.
- ERR_HDR: bytes 8'h01, 8'h7F, code, 8'h00; tx_last on byte 3; on accept -> IDLE with resp_error pulse.
- tx_valid, once high, stays high with tx_data/tx_last stable until accepted.
- slot_len/slot_valid_mask sampled only in CHECK; changes mid-response ignored.
- Reset at any point: message abandoned, no further bytes, return IDLE.

## Timing
- Reset values: req_ready=0, tx_valid=0, tx_data=0, tx_last=0, mem_rd_en=0, mem_addr=0, busy=0, resp_done=0, resp_error=0. req_ready=1 from first cycle after reset deasserts.
- Request accepted at edge T: CHECK in cycle T+1, first header byte tx_valid in T+2.
- Header/error bytes: 1 byte per cycle with tx_ready held high.
- Data bytes: 2 cycles per byte minimum (FETCH then SEND); n-byte response with tx_ready=1 completes 4+2n cycles after CHECK.
- resp_done/resp_error assert the cycle after the final transfer, coincident with req_ready=1.
- req_valid ignored while busy; request held upstream.

## Test plan
- Slot 0 len 100, req {01,82,00,00}, offset 0, length 16 -> header 01 02 00 00, 16 bytes mem addr 0..15, tx_last on 16th, resp_done pulse.
- Slot 2 len 100, offset 90, length 64 -> n=10, addresses {2,90..99}, tx_last on byte 10.
- Length 2000, offset 0, len 4000 -> exactly MAX_CHUNK=512 data bytes.
- Version 8'h02 -> 01 7F 02 00 with tx_last on byte 4, resp_error pulse, no mem_rd_en; offset=len -> code 01; unprovisioned slot 3 -> code 01.
- Random tx_ready backpressure (50%) during 32-byte response -> tx_data/tx_last stable while stalled, byte sequence identical to unstalled run.
- Reset asserted in SEND mid-chunk -> next cycle tx_valid=0, busy=0; following cycle req_ready=1; new request served correctly.

Source files
------------

// File: rtl/certificate_responder_if.sv
// rtl/certificate_responder_if.sv - request, chain-memory, response-byte and status signals of certificate_responder
interface certificate_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_header;
  logic [15:0] req_offset;
  logic [15:0] req_length;
  logic [3:0]  slot_valid_mask;
  logic [63:0] slot_len;
  logic        mem_rd_en;
  logic [17:0] mem_addr;
  logic [7:0]  mem_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        tx_last;
  logic        busy;
  logic        resp_done;
  logic        resp_error;

  modport slave (
    input  req_valid, req_header, req_offset, req_length, slot_valid_mask, slot_len,
           mem_data, tx_ready,
    output req_ready, mem_rd_en, mem_addr, tx_valid, tx_data, tx_last, busy,
           resp_done, resp_error
  );

  modport master (
    output req_valid, req_header, req_offset, req_length, slot_valid_mask, slot_len,
           mem_data, tx_ready,
    input  req_ready, mem_rd_en, mem_addr, tx_valid, tx_data, tx_last, busy,
           resp_done, resp_error
  );
endinterface

// File: rtl/certificate_responder.sv
// rtl/certificate_responder.sv - GET_CERTIFICATE responder: validates request, streams CERTIFICATE or ERROR bytes
module certificate_responder #(
  parameter logic [15:0] MAX_CHUNK = 16'd512
) (
  input logic clk,
  input logic reset,
  certificate_responder_if.slave bus
);

  typedef enum logic [2:0] {IDLE, CHECK, HDR, FETCH, SEND, ERR_HDR} state_t;

  state_t      state_q, state_d;
  logic [7:0]  ver_q, ver_d;
  logic [7:0]  type_q, type_d;
  logic [1:0]  slot_q, slot_d;
  logic [15:0] offset_q, offset_d;
  logic [15:0] length_q, length_d;
  logic [15:0] count_q, count_d;
  logic [15:0] idx_q, idx_d;
  logic [1:0]  hidx_q, hidx_d;
  logic [7:0]  code_q, code_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_done_q, resp_done_d;
  logic        resp_error_q, resp_error_d;

  logic [15:0] slot_len_sel;
  logic [15:0] avail;
  logic [15:0] n_c;
  logic [7:0]  chk_code;
  logic        unused_hdr_bits;

  assign unused_hdr_bits = ^{bus.req_header[15:10], bus.req_header[7:0]};
  assign slot_len_sel    = bus.slot_len[{slot_q, 4'b0000} +: 16];

  always_comb begin
    state_d      = state_q;
    ver_d        = ver_q;
    type_d       = type_q;
    slot_d       = slot_q;
    offset_d     = offset_q;
    length_d     = length_q;
    count_d      = count_q;
    idx_d        = idx_q;
    hidx_d       = hidx_q;
    code_d       = code_q;
    resp_done_d  = 1'b0;
    resp_error_d = 1'b0;
    avail        = 16'd0;
    n_c          = 16'd0;
    chk_code     = 8'h00;

    bus.tx_valid  = 1'b0;
    bus.tx_data   = 8'h00;
    bus.tx_last   = 1'b0;
    bus.mem_rd_en = 1'b0;
    bus.mem_addr  = 18'd0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          ver_d    = bus.req_header[31:24];
          type_d   = bus.req_header[23:16];
          slot_d   = bus.req_header[9:8];
          offset_d = bus.req_offset;
          length_d = bus.req_length;
          state_d  = CHECK;
        end
      end

      CHECK: begin
        // Ordered so the first failing check decides the error code.
        if (ver_q != 8'h01)                    chk_code = 8'h02;
        else if (type_q != 8'h82)              chk_code = 8'h01;
        else if (!bus.slot_valid_mask[slot_q]) chk_code = 8'h01;
        else if (length_q == 16'd0)            chk_code = 8'h01;
        else if (offset_q >= slot_len_sel)     chk_code = 8'h01;

        n_c = (length_q > MAX_CHUNK) ? MAX_CHUNK : length_q;
        if (offset_q < slot_len_sel) begin
          avail = slot_len_sel - offset_q;
          if (n_c > avail) n_c = avail;
        end

        count_d = n_c;
        code_d  = chk_code;
        hidx_d  = 2'd0;
        idx_d   = 16'd0;
        state_d = (chk_code != 8'h00) ? ERR_HDR : HDR;
      end

      HDR: begin
        bus.tx_valid = 1'b1;
        case (hidx_q)
          2'd0:    bus.tx_data = 8'h01;
          2'd1:    bus.tx_data = 8'h02;
          2'd2:    bus.tx_data = {6'b0, slot_q};
          default: bus.tx_data = 8'h00;
        endcase
        if (bus.tx_ready) begin
          if (hidx_q == 2'd3) state_d = FETCH;
          else                hidx_d  = hidx_q + 2'd1;
        end
      end

      FETCH: begin
        bus.mem_rd_en = 1'b1;
        bus.mem_addr  = {slot_q, offset_q + idx_q};
        state_d       = SEND;
      end

      SEND: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = bus.mem_data;
        bus.tx_last  = (idx_q == count_q - 16'd1);
        if (bus.tx_ready) begin
          if (idx_q == count_q - 16'd1) begin
            resp_done_d = 1'b1;
            state_d     = IDLE;
          end else begin
            idx_d   = idx_q + 16'd1;
            state_d = FETCH;
          end
        end
      end

      ERR_HDR: begin
        bus.tx_valid = 1'b1;
        bus.tx_last  = (hidx_q == 2'd3);
        case (hidx_q)
          2'd0:    bus.tx_data = 8'h01;
          2'd1:    bus.tx_data = 8'h7F;
          2'd2:    bus.tx_data = code_q;
          default: bus.tx_data = 8'h00;
        endcase
        if (bus.tx_ready) begin
          if (hidx_q == 2'd3) begin
            resp_error_d = 1'b1;
            state_d      = IDLE;
          end else begin
            hidx_d = hidx_q + 2'd1;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Registered so ready stays low for the cycle right after reset.
    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ver_q        <= 8'h00;
      type_q       <= 8'h00;
      slot_q       <= 2'd0;
      offset_q     <= 16'd0;
      length_q     <= 16'd0;
      count_q      <= 16'd0;
      idx_q        <= 16'd0;
      hidx_q       <= 2'd0;
      code_q       <= 8'h00;
      req_ready_q  <= 1'b0;
      resp_done_q  <= 1'b0;
      resp_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ver_q        <= ver_d;
      type_q       <= type_d;
      slot_q       <= slot_d;
      offset_q     <= offset_d;
      length_q     <= length_d;
      count_q      <= count_d;
      idx_q        <= idx_d;
      hidx_q       <= hidx_d;
      code_q       <= code_d;
      req_ready_q  <= req_ready_d;
      resp_done_q  <= resp_done_d;
      resp_error_q <= resp_error_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.resp_done  = resp_done_q;
  assign bus.resp_error = resp_error_q;

endmodule

// File: tb/tb_certificate_responder.sv
// tb/tb_certificate_responder.sv - scoreboard bench for certificate_responder
module tb_certificate_responder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  certificate_responder_if bus();

  certificate_responder #(.MAX_CHUNK(16'd512)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  logic [8:0] exp_q[$];

  localparam logic [63:0] SLOT_LENS = {16'd50, 16'd100, 16'd4000, 16'd100};
  localparam logic [3:0]  SLOT_MASK = 4'b0111;

  function automatic logic [7:0] mem_byte(input logic [17:0] a);
    return a[7:0] ^ a[15:8] ^ {a[17:16], 6'h15};
  endfunction

  always @(posedge clk) if (bus.mem_rd_en) bus.mem_data <= mem_byte(bus.mem_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic collect(input bit is_err, input int n, input bit stall);
    int cyc = 0;
    int rd = 0;
    bit hold = 0;
    logic [8:0] held = '0;
    logic [8:0] e;
    while (exp_q.size() > 0 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      bus.tx_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.mem_rd_en) rd++;
      if (cyc == 1) check("first_byte_valid", bus.tx_valid, 1);
      if (hold) begin
        check("stall_stable", {bus.tx_last, bus.tx_data}, held);
        hold = 0;
      end
      if (bus.tx_valid) begin
        if (bus.tx_ready) begin
          e = exp_q.pop_front();
          check("tx_byte", {bus.tx_last, bus.tx_data}, e);
        end else begin
          held = {bus.tx_last, bus.tx_data};
          hold = 1;
        end
      end
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $error("FAIL timeout: observed %0d bytes left expected 0", exp_q.size());
      exp_q.delete();
    end
    if (!stall) check("resp_cycles", cyc, is_err ? 4 : 4 + 2 * n);
    check("mem_reads", rd, is_err ? 0 : n);
    @(negedge clk);
    bus.tx_ready = 1'b1;
    check("resp_done", bus.resp_done, is_err ? 0 : 1);
    check("resp_error", bus.resp_error, is_err ? 1 : 0);
    check("ready_after", bus.req_ready, 1);
    check("busy_after", bus.busy, 0);
    @(negedge clk);
    check("pulse_single", bus.resp_done | bus.resp_error, 0);
  endtask

  task automatic drive_req(input logic [7:0] ver, input logic [7:0] typ, input logic [1:0] slot,
                           input logic [15:0] off, input logic [15:0] len);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_header = {ver, typ, 6'b0, slot, 8'h00};
    bus.req_offset = off;
    bus.req_length = len;
    check("ready_idle", bus.req_ready, 1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("check_busy", bus.busy, 1);
    check("check_no_tx", bus.tx_valid, 0);
  endtask

  task automatic run_req(input logic [7:0] ver, input logic [7:0] typ, input logic [1:0] slot,
                         input logic [15:0] off, input logic [15:0] len, input bit stall);
    int sl;
    int n;
    logic [7:0] code;
    logic [15:0] a;
    sl   = int'(SLOT_LENS[slot*16 +: 16]);
    code = 8'h00;
    n    = 0;
    if (ver != 8'h01)         code = 8'h02;
    else if (typ != 8'h82)    code = 8'h01;
    else if (!SLOT_MASK[slot]) code = 8'h01;
    else if (len == 16'd0)    code = 8'h01;
    else if (int'(off) >= sl) code = 8'h01;
    if (code != 8'h00) begin
      exp_q.push_back({1'b0, 8'h01});
      exp_q.push_back({1'b0, 8'h7F});
      exp_q.push_back({1'b0, code});
      exp_q.push_back({1'b1, 8'h00});
    end else begin
      n = int'(len);
      if (n > 512) n = 512;
      if (n > sl - int'(off)) n = sl - int'(off);
      exp_q.push_back({1'b0, 8'h01});
      exp_q.push_back({1'b0, 8'h02});
      exp_q.push_back({1'b0, 6'b0, slot});
      exp_q.push_back({1'b0, 8'h00});
      for (int i = 0; i < n; i++) begin
        a = off + 16'(i);
        exp_q.push_back({(i == n - 1), mem_byte({slot, a})});
      end
    end
    drive_req(ver, typ, slot, off, len);
    collect(code != 8'h00, n, stall);
  endtask

  initial begin
    bus.req_valid       = 1'b0;
    bus.req_header      = '0;
    bus.req_offset      = '0;
    bus.req_length      = '0;
    bus.tx_ready        = 1'b1;
    bus.slot_len        = SLOT_LENS;
    bus.slot_valid_mask = SLOT_MASK;
    bus.mem_data        = 8'h00;

    repeat (3) @(negedge clk);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_tx_valid", bus.tx_valid, 0);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_tx_last", bus.tx_last, 0);
    check("rst_mem_rd_en", bus.mem_rd_en, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.resp_done | bus.resp_error, 0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_rst", bus.req_ready, 1);

    run_req(8'h01, 8'h82, 2'd0, 16'd0,   16'd16,   1'b0);
    run_req(8'h01, 8'h82, 2'd2, 16'd90,  16'd64,   1'b0);
    run_req(8'h01, 8'h82, 2'd1, 16'd0,   16'd2000, 1'b0);
    run_req(8'h02, 8'h82, 2'd0, 16'd0,   16'd16,   1'b0);
    run_req(8'h01, 8'h82, 2'd0, 16'd100, 16'd4,    1'b0);
    run_req(8'h01, 8'h82, 2'd3, 16'd0,   16'd4,    1'b0);
    run_req(8'h01, 8'h81, 2'd0, 16'd0,   16'd4,    1'b0);
    run_req(8'h01, 8'h82, 2'd0, 16'd0,   16'd0,    1'b0);
    run_req(8'h01, 8'h82, 2'd1, 16'd300, 16'd32,   1'b1);

    // Reset while the second data byte is on the bus.
    drive_req(8'h01, 8'h82, 2'd0, 16'd0, 16'd16);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      bus.tx_ready = 1'b1;
    end
    check("mid_send_valid", bus.tx_valid, 1);
    check("mid_send_last", bus.tx_last, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_tx_valid", bus.tx_valid, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_ready_low", bus.req_ready, 0);
    check("abort_no_done", bus.resp_done, 0);
    @(negedge clk);
    check("abort_ready_high", bus.req_ready, 1);
    run_req(8'h01, 8'h82, 2'd2, 16'd5, 16'd5, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
